// File: rtl/pid_pkg.sv
// Shared types and defaults for the PID actuator output stage.
// Effort width, default PWM timing constants and the output FSM states.
package pid_pkg;
    localparam int EFFORT_W   = 16;
    localparam int PERIOD_DEF = 1000;
    localparam int U_MAX_DEF  = 1000;
    localparam int DEAD_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DEADT = 2'd2
    } pwm_state_t;
endpackage

// File: rtl/pwm_mag_sat.sv
// Effort magnitude with saturation: |u| clipped to U_MAX plus clip flag.
// Purely combinational, no flow control.
module pwm_mag_sat
    import pid_pkg::*;
#(
    parameter int U_MAX  = U_MAX_DEF,
    parameter int DUTY_W = 11
) (
    input  logic [EFFORT_W-1:0] u,
    output logic [DUTY_W-1:0]   duty,
    output logic                sat
);
    localparam logic [EFFORT_W:0] U_MAX_M = (EFFORT_W + 1)'(U_MAX);
    localparam logic [DUTY_W-1:0] U_MAX_D = DUTY_W'(U_MAX);

    logic [EFFORT_W:0] u_ext;
    logic [EFFORT_W:0] mag;

    // One extra bit so the most negative effort maps to +32768 cleanly.
    assign u_ext = {u[EFFORT_W-1], u};
    assign mag   = u[EFFORT_W-1] ? -u_ext : u_ext;
    assign sat   = (mag > U_MAX_M);
    assign duty  = sat ? U_MAX_D : mag[DUTY_W-1:0];
endmodule

// File: rtl/pid_pwm_out.sv
// Sign-magnitude H-bridge PWM with sample-rate tick, saturation and reversal dead time.
// Effort sampled on the period wrap edge, legs registered one cycle ahead of the counter; no backpressure.
module pid_pwm_out
    import pid_pkg::*;
#(
    parameter int PERIOD = PERIOD_DEF,
    parameter int CNT_W  = 10,
    parameter int U_MAX  = U_MAX_DEF,
    parameter int DEAD   = DEAD_DEF
) (
    input  logic                clk,
    input  logic                res,
    input  logic [EFFORT_W-1:0] u_in,
    input  logic                en,
    output logic                sample_tick,
    output logic                pwm_a,
    output logic                pwm_b,
    output logic                sat
);
    localparam int DUTY_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD - 1);

    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [DUTY_W-1:0] duty, duty_nx, duty_in;
    logic              dir, dir_nx;
    logic              sat_in, wrap, rev, leg_on;
    pwm_state_t        state, state_nx;

    pwm_mag_sat #(
        .U_MAX  (U_MAX),
        .DUTY_W (DUTY_W)
    ) u_mag_sat (
        .u    (u_in),
        .duty (duty_in),
        .sat  (sat_in)
    );

    assign wrap        = (cnt == CNT_LAST);
    assign sample_tick = wrap;
    assign cnt_nx      = wrap ? '0 : cnt + CNT_W'(1);
    assign rev         = (u_in[EFFORT_W-1] != dir) && (duty != '0);

    always_comb begin
        duty_nx  = duty;
        dir_nx   = dir;
        state_nx = state;
        if (wrap) begin
            duty_nx = duty_in;
            dir_nx  = u_in[EFFORT_W-1];
        end
        if (!en) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (wrap) state_nx = DEADT;
                RUN:     if (wrap && rev) state_nx = DEADT;
                DEADT:   if (cnt == DEAD_LAST) state_nx = RUN;
                default: state_nx = IDLE;
            endcase
        end
        // Legs are evaluated for the upcoming counter value so they are true flops.
        leg_on = (state_nx == RUN) && ({1'b0, cnt_nx} < duty_nx);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            cnt   <= '0;
            duty  <= '0;
            dir   <= 1'b0;
            state <= IDLE;
            sat   <= 1'b0;
            pwm_a <= 1'b0;
            pwm_b <= 1'b0;
        end else begin
            cnt   <= cnt_nx;
            duty  <= duty_nx;
            dir   <= dir_nx;
            state <= state_nx;
            if (wrap) sat <= sat_in;
            pwm_a <= leg_on && !dir_nx;
            pwm_b <= leg_on && dir_nx;
        end
    end
endmodule

// File: tb/tb_pid_pwm_out.sv
// Randomized and directed bench for pid_pwm_out against a period-level behavioural model.
module tb_pid_pwm_out;
    localparam int P  = 20;
    localparam int UM = 20;
    localparam int DT = 3;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        en  = 1'b1;
    logic [15:0] u_in = 16'd0;
    logic        sample_tick, pwm_a, pwm_b, sat;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: position in period, latched duty/dir/sat, whether the bridge is
    // enabled this period and whether this period opens with a dead window.
    int m_cnt, m_duty;
    bit m_dir, m_sat, m_active, m_dead;

    always #5 clk = ~clk;

    pid_pwm_out #(
        .PERIOD (P),
        .CNT_W  (5),
        .U_MAX  (UM),
        .DEAD   (DT)
    ) dut (
        .clk         (clk),
        .res         (res),
        .u_in        (u_in),
        .en          (en),
        .sample_tick (sample_tick),
        .pwm_a       (pwm_a),
        .pwm_b       (pwm_b),
        .sat         (sat)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t (cnt=%0d)", tag, got, exp, $time, m_cnt);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_duty = 0; m_dir = 0; m_sat = 0; m_active = 0; m_dead = 0;
    endtask

    task automatic model_edge(input logic [15:0] u, input logic e);
        int s, mag;
        bit wrap, nd, rv;
        wrap  = (m_cnt == P - 1);
        m_cnt = wrap ? 0 : m_cnt + 1;
        if (wrap) begin
            s   = $signed(u);
            mag = (s < 0) ? -s : s;
            nd  = (s < 0);
            rv  = (nd != m_dir) && (m_duty != 0);
            m_dead   = !m_active || rv;
            m_duty   = (mag > UM) ? UM : mag;
            m_sat    = (mag > UM);
            m_dir    = nd;
            m_active = 1;
        end
        if (!e) m_active = 0;
    endtask

    task automatic compare_all();
        bit on;
        on = m_active && (m_cnt < m_duty) && !(m_dead && m_cnt < DT);
        chk("tick",  sample_tick, m_cnt == P - 1);
        chk("pwm_a", pwm_a, on && !m_dir);
        chk("pwm_b", pwm_b, on && m_dir);
        chk("sat",   sat, m_sat);
        chk("excl",  pwm_a && pwm_b, 0);
    endtask

    task automatic run_cycle(input logic [15:0] u, input logic e);
        u_in = u;
        en   = e;
        @(posedge clk);
        if (res) model_edge(u, e);
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_until(input int target, input logic [15:0] u, input logic e);
        for (int i = 0; i < 2 * P && m_cnt != target; i++) run_cycle(u, e);
    endtask

    function automatic logic [15:0] rand_u();
        logic [15:0] v;
        case ($urandom_range(0, 5))
            0: v = 16'd0;
            1: begin
                v = 16'($urandom_range(0, 25));
                if ($urandom_range(0, 1) == 1) v = -v;
            end
            2: v = 16'h8000;
            3: v = 16'h7fff;
            4: v = ($urandom_range(0, 1) == 1) ? 16'hffec : 16'd21;
            default: v = 16'($urandom);
        endcase
        return v;
    endfunction

    logic [15:0] steps_u [6] = '{16'd0, 16'd5, 16'd8, 16'hfff8, 16'h8000, 16'd20};
    int          steps_n [6] = '{2, 3, 2, 2, 2, 2};

    initial begin
        logic e_r;
        model_reset();
        #2;
        compare_all();
        @(negedge clk);
        res = 1'b1;

        for (int k = 0; k < 6; k++) begin
            run_until(P - 1, steps_u[k], 1'b1);
            repeat (steps_n[k] * P) run_cycle(steps_u[k], 1'b1);
        end

        // Mid-period effort change must not reach the legs before the next period.
        run_until(7, 16'd20, 1'b1);
        repeat (2 * P) run_cycle(16'd3, 1'b1);

        // Enable dropped at cnt=4 with duty 10, then restored.
        run_until(P - 1, 16'd10, 1'b1);
        repeat (2 * P) run_cycle(16'd10, 1'b1);
        run_until(4, 16'd10, 1'b1);
        repeat (P) run_cycle(16'd10, 1'b0);
        repeat (3 * P) run_cycle(16'd10, 1'b1);

        // Asynchronous reset while the reverse leg is saturated on.
        run_until(P - 1, 16'h8000, 1'b1);
        repeat (P + 7) run_cycle(16'h8000, 1'b1);
        #3 res = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge clk);
        repeat (2) run_cycle(16'h8000, 1'b1);
        res = 1'b1;
        repeat (3 * P) run_cycle(16'h8000, 1'b1);

        e_r = 1'b1;
        repeat (60 * P) begin
            if ($urandom_range(0, 29) == 0) e_r = !e_r;
            run_cycle(rand_u(), e_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end
endmodule
